sdfm_sinc_filt: RTL and testbench

- Next-generation sigma-delta data filter channel: parametrised sinc1/sinc2/sinc3/sincfast CIC decimator.
- Runs entirely in the SYSCLK domain. The modulator clock arrives as a one-cycle synchronous strobe (sd_clk_en) from the upstream input-qualification block.
- Adds output saturation to a configurable width, deterministic output latency, and suppression of unsettled outputs after enable or mode change.
- Output feeds the existing FIFO/register path through filt_data_out/filt_data_update.

---
 rtl/sdfm_sinc_filt_if.sv | 37 +++
 rtl/sdfm_sinc_filt.sv | 123 ++++++++++++
 tb/tb_sdfm_sinc_filt.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdfm_sinc_filt_if.sv
// ============================================================================
// Module  : sdfm_sinc_filt_if
// Brief   : Bitstream, register and filtered-output bundle for the sinc channel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdfm_sinc_filt_if #(
  parameter int DEC_W = 8,
  parameter int OUT_W = 16
);
  logic             sd_clk_en;
  logic             sd_dsd_in;
  logic             reg_filten;
  logic [1:0]       reg_filtst;
  logic [DEC_W-1:0] reg_filtdec;
  logic [4:0]       reg_filtsh;
  logic             reg_filtsat;
  logic [OUT_W-1:0] filt_data_out;
  logic             filt_data_update;
  logic             filt_sat;
  logic             filt_settled;

  modport master (
    output sd_clk_en, sd_dsd_in, reg_filten, reg_filtst, reg_filtdec,
           reg_filtsh, reg_filtsat,
    input  filt_data_out, filt_data_update, filt_sat, filt_settled
  );

  modport slave (
    input  sd_clk_en, sd_dsd_in, reg_filten, reg_filtst, reg_filtdec,
           reg_filtsh, reg_filtsat,
    output filt_data_out, filt_data_update, filt_sat, filt_settled
  );
endinterface

`default_nettype wire

// File: rtl/sdfm_sinc_filt.sv
// ============================================================================
// Module  : sdfm_sinc_filt
// Brief   : sinc1/2/3/fast CIC decimator with shift, saturation and settling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdfm_sinc_filt #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int DEC_W = 8
) (
  input  logic            SYSCLK,
  input  logic            SYSRSTn,
  sdfm_sinc_filt_if.slave filt_if
);
  localparam logic [ACC_W-1:0] c_POS_ONE = ACC_W'(1);
  localparam logic [ACC_W-1:0] c_NEG_ONE = '1;
  localparam logic [4:0]       c_SH_MAX  = 5'd24;

  logic [ACC_W-1:0] i1_q, i2_q, i3_q;
  logic [ACC_W-1:0] x_q, q1_q, q2_q, q2p_q;
  logic [DEC_W-1:0] cnt_q;
  logic             pend_q, en_q, settled_q, upd_q, sat_q;
  logic [1:0]       st_q;
  logic [2:0]       settle_q;
  logic [OUT_W-1:0] out_q;

  logic                    w_event, w_load, w_ovf;
  logic [ACC_W-1:0]        x_d, q1_d, q2_d, q3_d, res_d;
  logic signed [ACC_W-1:0] w_shifted;
  logic [ACC_W-OUT_W:0]    w_top;
  logic [4:0]              w_sh;
  logic [2:0]              w_settle_n;
  logic [OUT_W-1:0]        out_d;

  always_comb begin
    w_event = filt_if.sd_clk_en && (cnt_q >= filt_if.reg_filtdec);
    // A structure change restarts settling just like a fresh enable.
    w_load  = !en_q || (st_q != filt_if.reg_filtst);
    case (filt_if.reg_filtst)
      2'b01:   begin x_d = i1_q; w_settle_n = 3'd1; end
      2'b10:   begin x_d = i2_q; w_settle_n = 3'd2; end
      2'b11:   begin x_d = i3_q; w_settle_n = 3'd3; end
      default: begin x_d = i2_q; w_settle_n = 3'd4; end
    endcase
    q1_d = x_d - x_q;
    q2_d = q1_d - q1_q;
    q3_d = q2_d - q2_q;
    case (filt_if.reg_filtst)
      2'b01:   res_d = q1_d;
      2'b10:   res_d = q2_d;
      2'b11:   res_d = q3_d;
      default: res_d = q2_d + q2p_q;
    endcase
    w_sh      = (filt_if.reg_filtsh > c_SH_MAX) ? c_SH_MAX : filt_if.reg_filtsh;
    w_shifted = $signed(res_d) >>> w_sh;
    // In range only when every bit above the output sign bit matches it.
    w_top     = w_shifted[ACC_W-1:OUT_W-1];
    w_ovf     = !((&w_top) || !(|w_top));
    if (w_ovf && filt_if.reg_filtsat) begin
      out_d = w_shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      out_d = w_shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      i1_q <= '0; i2_q <= '0; i3_q <= '0;
      x_q <= '0; q1_q <= '0; q2_q <= '0; q2p_q <= '0;
      cnt_q <= '0; pend_q <= 1'b0; en_q <= 1'b0; st_q <= 2'b00;
      settle_q <= 3'd0; settled_q <= 1'b0;
      out_q <= '0; upd_q <= 1'b0; sat_q <= 1'b0;
    end else if (!filt_if.reg_filten) begin
      i1_q <= '0; i2_q <= '0; i3_q <= '0;
      x_q <= '0; q1_q <= '0; q2_q <= '0; q2p_q <= '0;
      cnt_q <= '0; pend_q <= 1'b0; en_q <= 1'b0; st_q <= 2'b00;
      settle_q <= 3'd0; settled_q <= 1'b0;
      out_q <= '0; upd_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      en_q   <= 1'b1;
      st_q   <= filt_if.reg_filtst;
      upd_q  <= 1'b0;
      sat_q  <= 1'b0;
      pend_q <= w_event;
      if (filt_if.sd_clk_en) begin
        i1_q  <= i1_q + (filt_if.sd_dsd_in ? c_POS_ONE : c_NEG_ONE);
        i2_q  <= i2_q + i1_q;
        i3_q  <= i3_q + i2_q;
        cnt_q <= w_event ? '0 : cnt_q + DEC_W'(1);
      end
      if (pend_q) begin
        x_q   <= x_d;
        q1_q  <= q1_d;
        q2_q  <= q2_d;
        q2p_q <= q2_q;
        if (!w_load) begin
          if (!settled_q) begin
            settle_q  <= settle_q - 3'd1;
            settled_q <= (settle_q == 3'd1);
          end else begin
            out_q <= out_d;
            upd_q <= 1'b1;
            sat_q <= w_ovf;
          end
        end
      end
      if (w_load) begin
        settle_q  <= w_settle_n;
        settled_q <= 1'b0;
      end
    end
  end

  assign filt_if.filt_data_out    = out_q;
  assign filt_if.filt_data_update = upd_q;
  assign filt_if.filt_sat         = sat_q;
  assign filt_if.filt_settled     = settled_q;

endmodule

`default_nettype wire

// File: tb/tb_sdfm_sinc_filt.sv
// ============================================================================
// Module  : tb_sdfm_sinc_filt
// Brief   : Randomised and directed bench for the sinc filter channel.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sdfm_sinc_filt;
  localparam int ACC_W = 32;
  localparam int OUT_W = 16;
  localparam int DEC_W = 8;

  typedef struct packed {
    logic             upd;
    logic             sat;
    logic             settled;
    logic [OUT_W-1:0] data;
  } obs_t;

  logic SYSCLK  = 1'b0;
  logic SYSRSTn = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  sdfm_sinc_filt_if #(.DEC_W(DEC_W), .OUT_W(OUT_W)) bus ();

  sdfm_sinc_filt #(.ACC_W(ACC_W), .OUT_W(OUT_W), .DEC_W(DEC_W)) dut (
    .SYSCLK  (SYSCLK),
    .SYSRSTn (SYSRSTn),
    .filt_if (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Reference: integrators as plain sums, combs as binomial differences of
  // the integrator value captured at each decimation event.
  longint           m_i1, m_i2, m_i3;
  longint           m_h[5];
  int               m_cnt, m_settle;
  bit               m_pend, m_prev_en, m_upd, m_sat, m_settled;
  logic [1:0]       m_prev_st;
  logic [OUT_W-1:0] m_data;

  function automatic void model_clear();
    m_i1 = 0; m_i2 = 0; m_i3 = 0;
    foreach (m_h[k]) m_h[k] = 0;
    m_cnt = 0; m_settle = 0; m_pend = 0; m_prev_en = 0; m_prev_st = 2'b00;
    m_upd = 0; m_sat = 0; m_settled = 0; m_data = '0;
  endfunction

  function automatic void model_step();
    bit                      load, ev;
    longint                  x, r, sh, lim_hi, lim_lo;
    logic signed [ACC_W-1:0] r32;
    int                      n_set;
    if (!bus.reg_filten) begin
      model_clear();
      return;
    end
    lim_hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lim_lo = -lim_hi - 1;
    ev     = 0;
    load   = !m_prev_en || (bus.reg_filtst != m_prev_st);
    case (bus.reg_filtst)
      2'b01:   begin x = m_i1; n_set = 1; end
      2'b10:   begin x = m_i2; n_set = 2; end
      2'b11:   begin x = m_i3; n_set = 3; end
      default: begin x = m_i2; n_set = 4; end
    endcase
    m_upd = 0;
    m_sat = 0;
    if (m_pend) begin
      for (int k = 4; k > 0; k--) m_h[k] = m_h[k-1];
      m_h[0] = x;
      case (bus.reg_filtst)
        2'b01:   r = m_h[0] - m_h[1];
        2'b10:   r = m_h[0] - 2*m_h[1] + m_h[2];
        2'b11:   r = m_h[0] - 3*m_h[1] + 3*m_h[2] - m_h[3];
        default: r = m_h[0] - 2*m_h[1] + 2*m_h[2] - 2*m_h[3] + m_h[4];
      endcase
      r32 = r[ACC_W-1:0];
      sh  = (bus.reg_filtsh > 5'd24) ? 24 : longint'(bus.reg_filtsh);
      r   = longint'(r32) >>> sh;
      if (!load) begin
        if (m_settle > 0) begin
          m_settle--;
          if (m_settle == 0) m_settled = 1;
        end else begin
          m_upd = 1;
          m_sat = (r > lim_hi) || (r < lim_lo);
          if (m_sat && bus.reg_filtsat)
            m_data = (r < 0) ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
          else
            m_data = r[OUT_W-1:0];
        end
      end
    end
    if (load) begin
      m_settle  = n_set;
      m_settled = 0;
    end
    if (bus.sd_clk_en) begin
      ev   = (m_cnt >= int'(bus.reg_filtdec));
      m_i3 = m_i3 + m_i2;
      m_i2 = m_i2 + m_i1;
      m_i1 = m_i1 + (bus.sd_dsd_in ? 1 : -1);
      m_cnt = ev ? 0 : m_cnt + 1;
    end
    m_pend    = ev;
    m_prev_en = 1;
    m_prev_st = bus.reg_filtst;
  endfunction

  task automatic cfg(input bit en, input logic [1:0] st, input int dec, input int sh, input bit sat);
    bus.reg_filten  = en;
    bus.reg_filtst  = st;
    bus.reg_filtdec = DEC_W'(dec);
    bus.reg_filtsh  = 5'(sh);
    bus.reg_filtsat = sat;
  endtask

  task automatic step(input bit stb, input bit b, output obs_t e, output obs_t o);
    bus.sd_clk_en = stb;
    bus.sd_dsd_in = b;
    @(posedge SYSCLK);
    if (!SYSRSTn) model_clear();
    else          model_step();
    #1;
    e = {m_upd, m_sat, m_settled, m_data};
    o = {bus.filt_data_update, bus.filt_sat, bus.filt_settled, bus.filt_data_out};
  endtask

  task automatic test_reset();
    obs_t e, o;
    cfg(1'b0, 2'b01, 0, 0, 1'b0);
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, e, o);
      n_vec++;
      if (o !== obs_t'(0)) begin n_err++; $display("FAIL reset cyc %0d: got %h want 0", i, o); end
    end
    @(negedge SYSCLK);
    SYSRSTn = 1'b1;
  endtask

  task automatic test_sinc1();
    obs_t e, o;
    logic [OUT_W-1:0] last = '0;
    int nupd = 0;
    cfg(1'b1, 2'b01, 3, 0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL sinc1 cyc %0d: got %h want %h", i, o, e); end
      if (o.upd) begin last = o.data; nupd++; end
    end
    n_vec++;
    if (nupd == 0 || last !== 16'd4 || o.settled !== 1'b1) begin
      n_err++; $display("FAIL sinc1_value: got data=%0d updates=%0d settled=%b want data=4 updates>0 settled=1", last, nupd, o.settled);
    end
  endtask

  task automatic test_sinc3();
    obs_t e, o;
    logic [OUT_W-1:0] last = '0;
    cfg(1'b0, 2'b11, 15, 4, 1'b1);
    step(1'b0, 1'b0, e, o);
    cfg(1'b1, 2'b11, 15, 4, 1'b1);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, (i < 100) ? 1'b1 : 1'(i % 2), e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL sinc3 cyc %0d: got %h want %h", i, o, e); end
      if (o.upd) last = o.data;
      if (i == 99) begin
        n_vec++;
        if (last !== 16'd256) begin n_err++; $display("FAIL sinc3_ones: got %0d want 256", last); end
      end
    end
    n_vec++;
    if (last !== 16'd0) begin n_err++; $display("FAIL sinc3_alt: got %0d want 0", last); end
  endtask

  task automatic test_fast_sinc2();
    obs_t e, o;
    logic [OUT_W-1:0] last = '0;
    cfg(1'b0, 2'b00, 3, 0, 1'b1);
    step(1'b0, 1'b0, e, o);
    cfg(1'b1, 2'b00, 3, 0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      if (i == 40) cfg(1'b1, 2'b10, 3, 0, 1'b1);
      step(1'b1, 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL fast_sinc2 cyc %0d: got %h want %h", i, o, e); end
      if (o.upd) last = o.data;
      if (i == 39) begin
        n_vec++;
        if (last !== 16'd32) begin n_err++; $display("FAIL sincfast_value: got %0d want 32", last); end
      end
    end
    n_vec++;
    if (last !== 16'd16) begin n_err++; $display("FAIL sinc2_value: got %0d want 16", last); end
  endtask

  task automatic test_saturation();
    obs_t e, o;
    logic [OUT_W-1:0] last = '0;
    int nupd = 0, nsat = 0;
    cfg(1'b0, 2'b11, 63, 0, 1'b1);
    step(1'b0, 1'b0, e, o);
    cfg(1'b1, 2'b11, 63, 0, 1'b1);
    for (int i = 0; i < 1152; i++) begin
      if (i == 768) cfg(1'b1, 2'b11, 63, 0, 1'b0);
      step(1'b1, (i >= 384 && i < 768) ? 1'b0 : 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL saturation cyc %0d: got %h want %h", i, o, e); end
      if (o.upd) begin last = o.data; nupd++; if (o.sat) nsat++; end
      if (i == 383 || i == 767) begin
        n_vec++;
        if (last !== ((i == 383) ? 16'h7fff : 16'h8000)) begin
          n_err++; $display("FAIL sat_clamp at %0d: got %h want %h", i, last, (i == 383) ? 16'h7fff : 16'h8000);
        end
      end
    end
    n_vec++;
    if (last !== 16'd0 || nsat != nupd || nupd == 0) begin
      n_err++; $display("FAIL sat_wrap: got data=%0d sat_pulses=%0d updates=%0d want data=0 and a sat pulse on every update", last, nsat, nupd);
    end
  endtask

  task automatic test_mode_change();
    obs_t e, o;
    logic [OUT_W-1:0] last = '0;
    int quiet_bad = 0;
    cfg(1'b0, 2'b01, 3, 0, 1'b1);
    step(1'b0, 1'b0, e, o);
    cfg(1'b1, 2'b01, 3, 0, 1'b1);
    for (int i = 0; i < 80; i++) begin
      if (i == 30) cfg(1'b1, 2'b11, 3, 0, 1'b1);
      step(1'b1, 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL mode_change cyc %0d: got %h want %h", i, o, e); end
      if (i >= 30 && i < 40 && (o.upd || o.settled)) quiet_bad++;
      if (o.upd) last = o.data;
    end
    n_vec++;
    if (quiet_bad != 0 || last !== 16'd64) begin
      n_err++; $display("FAIL mode_change_settle: got busy_cycles=%0d data=%0d want 0 and 64", quiet_bad, last);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int nupd = 0, nbad = 0;
    cfg(1'b0, 2'b01, 0, 0, 1'b1);
    step(1'b0, 1'b0, e, o);
    cfg(1'b1, 2'b01, 0, 0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL back_to_back cyc %0d: got %h want %h", i, o, e); end
      if (i >= 10) begin
        if (o.upd) nupd++;
        if (o.data !== 16'd1) nbad++;
      end
    end
    n_vec++;
    if (nupd != 20 || nbad != 0) begin
      n_err++; $display("FAIL back_to_back_rate: got updates=%0d bad_data=%0d want 20 and 0", nupd, nbad);
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    cfg(1'b0, 2'b01, 7, 0, 1'b1);
    step(1'b0, 1'b0, e, o);
    cfg(1'b1, 2'b01, 7, 0, 1'b1);
    for (int i = 0; i < 45; i++) begin
      step(1'b1, 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL pre_reset cyc %0d: got %h want %h", i, o, e); end
    end
    #2;
    SYSRSTn = 1'b0;
    model_clear();
    #1;
    o = {bus.filt_data_update, bus.filt_sat, bus.filt_settled, bus.filt_data_out};
    n_vec++;
    if (o !== obs_t'(0)) begin n_err++; $display("FAIL async_reset: got %h want 0", o); end
    step(1'b1, 1'b1, e, o);
    @(negedge SYSCLK);
    SYSRSTn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1, e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL post_reset cyc %0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_enable_toggle();
    obs_t e, o;
    int nz = 0;
    cfg(1'b1, 2'b10, 5, 1, 1'b1);
    for (int i = 0; i < 90; i++) begin
      if (i == 40) bus.reg_filten = 1'b0;
      if (i == 46) bus.reg_filten = 1'b1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL enable_toggle cyc %0d: got %h want %h", i, o, e); end
      if (i > 40 && i <= 46 && o !== obs_t'(0)) nz++;
    end
    n_vec++;
    if (nz != 0) begin n_err++; $display("FAIL enable_off_outputs: got %0d nonzero cycles want 0", nz); end
  endtask

  task automatic test_random();
    obs_t e, o;
    cfg(1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4000; i++) begin
      bus.reg_filten = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 249) == 0) bus.reg_filtst  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)  bus.reg_filtdec = DEC_W'($urandom_range(0, 63));
      if ($urandom_range(0, 49) == 0)  bus.reg_filtsh  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0)  bus.reg_filtsat = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), e, o);
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL random cyc %0d: got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    bus.sd_clk_en = 1'b0;
    bus.sd_dsd_in = 1'b0;
    cfg(1'b0, 2'b00, 0, 0, 1'b0);
    model_clear();
    test_reset();
    test_sinc1();
    test_sinc3();
    test_fast_sinc2();
    test_saturation();
    test_mode_change();
    test_back_to_back();
    test_async_reset();
    test_enable_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
